// File: rtl/shutdown_sequencer_if.sv
// Signal bundle between the shutdown FSM / actuator drivers and the staged power sequencer.
// The slave modport is the sequencer side; the master modport is the surrounding system.
interface shutdown_sequencer_if #(
    parameter int N_CH = 4
);
    logic            shutdown_req;
    logic [N_CH-1:0] ch_fb;
    logic            clear_fault;
    logic [N_CH-1:0] ch_en;
    logic            seq_busy;
    logic            all_on;
    logic            all_off;
    logic            fb_fault;
    logic [2:0]      stage_idx;

    modport master (
        output shutdown_req, ch_fb, clear_fault,
        input  ch_en, seq_busy, all_on, all_off, fb_fault, stage_idx
    );

    modport slave (
        input  shutdown_req, ch_fb, clear_fault,
        output ch_en, seq_busy, all_on, all_off, fb_fault, stage_idx
    );
endinterface

// File: rtl/shutdown_sequencer.sv
// Staged power sequencer: energises channels in ascending order, de-energises in descending order,
// confirming every step against channel feedback and latching a sticky fault on any mismatch.
module shutdown_sequencer #(
    parameter int N_CH       = 4,
    parameter int GAP_CYC    = 16,
    parameter int FB_TIMEOUT = 64,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shutdown_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_OFF,
        S_UP_CONF,
        S_UP_GAP,
        S_ON,
        S_DN_CONF,
        S_DN_GAP
    } state_t;

    localparam logic [CNT_W-1:0] FB_LAST  = CNT_W'(FB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [2:0]       IDX_LAST = 3'(N_CH - 1);

    state_t            state_reg, state_next;
    logic [2:0]        idx_reg, idx_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [N_CH-1:0]   ch_en_reg, ch_en_next;
    logic              fb_fault_reg, fb_fault_next;
    logic              seq_busy_reg;
    logic              all_on_reg;
    logic              all_off_reg;

    logic [N_CH-1:0]   idx_onehot;
    logic [N_CH-1:0]   hi_onehot;
    logic [2:0]        hi_idx;
    logic              any_en;
    logic              fb_at_idx;
    logic              fb_all_on;
    logic              start_dn;
    logic [CNT_W-1:0]  cnt_inc;

    // One-hot of the current step keeps every channel select in range for any N_CH.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_idx_dec
            assign idx_onehot[gi] = (idx_reg == 3'(gi));
        end
    endgenerate

    assign fb_at_idx = |(bus.ch_fb & idx_onehot);
    assign fb_all_on = &bus.ch_fb;
    assign any_en    = |ch_en_reg;
    assign cnt_inc   = cnt_reg + 1'b1;

    always_comb begin
        hi_idx    = '0;
        hi_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_en_reg[i]) begin
                hi_idx       = 3'(i);
                hi_onehot    = '0;
                hi_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        cnt_next      = cnt_reg;
        ch_en_next    = ch_en_reg;
        fb_fault_next = fb_fault_reg;
        start_dn      = 1'b0;

        case (state_reg)
            S_OFF: begin
                ch_en_next = '0;
                // A clear pulse consumes the cycle; starting waits for a later one.
                if (bus.clear_fault) begin
                    fb_fault_next = 1'b0;
                end else if (!bus.shutdown_req && !fb_fault_reg && (bus.ch_fb == '0)) begin
                    state_next = S_UP_CONF;
                    ch_en_next = N_CH'(1);
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            end

            S_UP_CONF: begin
                if (bus.shutdown_req) begin
                    start_dn = 1'b1;
                end else if (fb_at_idx) begin
                    state_next = S_UP_GAP;
                    cnt_next   = '0;
                end else if (cnt_reg == FB_LAST) begin
                    fb_fault_next = 1'b1;
                    start_dn      = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            S_UP_GAP: begin
                if (bus.shutdown_req) begin
                    start_dn = 1'b1;
                end else if (cnt_reg == GAP_LAST) begin
                    cnt_next = '0;
                    if (idx_reg == IDX_LAST) begin
                        state_next = S_ON;
                    end else begin
                        state_next = S_UP_CONF;
                        idx_next   = idx_reg + 3'd1;
                        ch_en_next = ch_en_reg | (idx_onehot << 1);
                    end
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            S_ON: begin
                if (bus.shutdown_req) begin
                    start_dn = 1'b1;
                end else if (!fb_all_on) begin
                    fb_fault_next = 1'b1;
                    start_dn      = 1'b1;
                end
            end

            S_DN_CONF: begin
                // A stuck channel ends the orderly sequence: everything drops at once.
                if (cnt_reg == FB_LAST) begin
                    fb_fault_next = 1'b1;
                    ch_en_next    = '0;
                    cnt_next      = '0;
                    state_next    = S_OFF;
                end else if (!fb_at_idx) begin
                    state_next = S_DN_GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            S_DN_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next = '0;
                    if (idx_reg == 3'd0) begin
                        state_next = S_OFF;
                    end else begin
                        state_next = S_DN_CONF;
                        idx_next   = idx_reg - 3'd1;
                        ch_en_next = ch_en_reg & ~(idx_onehot >> 1);
                    end
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            default: begin
                state_next = S_OFF;
                ch_en_next = '0;
                cnt_next   = '0;
            end
        endcase

        // Down sequence begins at the highest channel currently driven.
        if (start_dn) begin
            cnt_next = '0;
            if (any_en) begin
                state_next = S_DN_CONF;
                idx_next   = hi_idx;
                ch_en_next = ch_en_reg & ~hi_onehot;
            end else begin
                state_next = S_OFF;
                ch_en_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_OFF;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            ch_en_reg    <= '0;
            fb_fault_reg <= 1'b0;
            seq_busy_reg <= 1'b0;
            all_on_reg   <= 1'b0;
            all_off_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            cnt_reg      <= cnt_next;
            ch_en_reg    <= ch_en_next;
            fb_fault_reg <= fb_fault_next;
            seq_busy_reg <= (state_next != S_OFF) && (state_next != S_ON);
            all_on_reg   <= (state_next == S_ON);
            all_off_reg  <= (state_next == S_OFF);
        end
    end

    assign bus.ch_en     = ch_en_reg;
    assign bus.seq_busy  = seq_busy_reg;
    assign bus.all_on    = all_on_reg;
    assign bus.all_off   = all_off_reg;
    assign bus.fb_fault  = fb_fault_reg;
    assign bus.stage_idx = idx_reg;

endmodule
